ps2_mouse_ctrl: RTL and testbench

- Host-side sequencer for the PS/2 mouse path.
- Drives a byte transmitter to initialise the mouse: reset, self-test check, enable streaming.
- Pulls received bytes from the PS/2 receiver through its rd_en/rd_vld handshake.
- Assembles 3-byte movement packets into clamped absolute cursor coordinates and button state for the display logic.

---
 rtl/ps2_mouse_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_ps2_mouse_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/ps2_mouse_ctrl.sv
// PS/2 mouse host sequencer: reset/self-test/enable handshake, then 3-byte packet decode to a clamped cursor.
// Optional init-byte timeout and timeout-driven retries are enabled with `define PS2_TIMEOUT_EN.
module ps2_mouse_ctrl #(
  parameter int X_MAX       = 159,
  parameter int Y_MAX       = 119,
  parameter int POS_W       = 8,
  parameter int TIMEOUT_CYC = 50_000_000,
  parameter int MAX_RETRY   = 3
) (
  input  logic             clk_sys,
  input  logic             rst_n,
  output logic             tx_req,
  output logic [7:0]       tx_data,
  input  logic             tx_done,
  output logic             rx_rd_en,
  input  logic             rx_rd_vld,
  input  logic [7:0]       rx_rd_data,
  output logic [POS_W-1:0] mouse_x,
  output logic [POS_W-1:0] mouse_y,
  output logic [2:0]       mouse_btn,
  output logic             pkt_vld,
  output logic             init_done,
  output logic             init_err
);

  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam logic signed [POS_W+1:0] XMAX_S = (POS_W+2)'(X_MAX);
  localparam logic signed [POS_W+1:0] YMAX_S = (POS_W+2)'(Y_MAX);

  typedef enum logic [3:0] {
    S_SEND_RST, S_TX_WAIT1, S_WAIT_ACK1, S_WAIT_BAT, S_WAIT_ID,
    S_SEND_EN, S_TX_WAIT2, S_WAIT_ACK2, S_B0, S_B1, S_B2, S_ERR
  } state_t;

  state_t           state_q, state_d;
  logic [RW-1:0]    retry_q;
  logic [7:0]       b0_q, dx_q;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_req_q, tx_req_d;
  logic             pkt_vld_q, init_done_q;
  logic [POS_W-1:0] x_q, y_q, x_new, y_new;
  logic [2:0]       btn_q;
  logic             consume, fail, tmo, timed;
  logic             rd_en_c, err_c;

  // Sign-extend a 9-bit PS/2 delta {sign, magnitude byte} to the working width.
  function automatic logic signed [POS_W+1:0] sext9(input logic sgn, input logic [7:0] mag);
    sext9 = signed'({{(POS_W-7){sgn}}, sgn, mag});
  endfunction

  function automatic logic [POS_W-1:0] clamp_pos(input logic signed [POS_W+1:0] v,
                                                 input logic signed [POS_W+1:0] vmax);
    if (v < 0)         clamp_pos = '0;
    else if (v > vmax) clamp_pos = vmax[POS_W-1:0];
    else               clamp_pos = v[POS_W-1:0];
  endfunction

  assign consume = rd_en_c && rx_rd_vld;
  assign timed   = (state_q == S_TX_WAIT1) || (state_q == S_TX_WAIT2) ||
                   (state_q == S_WAIT_ACK1) || (state_q == S_WAIT_BAT) ||
                   (state_q == S_WAIT_ID) || (state_q == S_WAIT_ACK2);

`ifdef PS2_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] timer_q, timer_d;

  assign tmo = timed && (timer_q == TW'(TIMEOUT_CYC - 1));

  always_comb begin
    timer_d = '0;
    if (timed && (state_d == state_q)) timer_d = timer_q + 1'b1;
  end

  always_ff @(posedge clk_sys) begin
    if (!rst_n) timer_q <= '0;
    else        timer_q <= timer_d;
  end
`else
  assign tmo = 1'b0;
`endif

  // State register
  always_ff @(posedge clk_sys) begin
    if (!rst_n) state_q <= S_SEND_RST;
    else        state_q <= state_d;
  end

  // Next-state logic; any init failure funnels through `fail`.
  always_comb begin
    state_d = state_q;
    fail    = 1'b0;
    case (state_q)
      S_SEND_RST: state_d = S_TX_WAIT1;
      S_TX_WAIT1: if (tmo) fail = 1'b1; else if (tx_done) state_d = S_WAIT_ACK1;
      S_WAIT_ACK1: begin
        if (tmo) fail = 1'b1;
        else if (consume) begin
          if (rx_rd_data == 8'hFA) state_d = S_WAIT_BAT; else fail = 1'b1;
        end
      end
      S_WAIT_BAT: begin
        if (tmo) fail = 1'b1;
        else if (consume) begin
          if (rx_rd_data == 8'hAA) state_d = S_WAIT_ID; else fail = 1'b1;
        end
      end
      S_WAIT_ID: begin
        if (tmo) fail = 1'b1;
        else if (consume) begin
          if (rx_rd_data == 8'h00) state_d = S_SEND_EN; else fail = 1'b1;
        end
      end
      S_SEND_EN:  state_d = S_TX_WAIT2;
      S_TX_WAIT2: if (tmo) fail = 1'b1; else if (tx_done) state_d = S_WAIT_ACK2;
      S_WAIT_ACK2: begin
        if (tmo) fail = 1'b1;
        else if (consume) begin
          if (rx_rd_data == 8'hFA) state_d = S_B0; else fail = 1'b1;
        end
      end
      S_B0:    if (consume && rx_rd_data[3]) state_d = S_B1;
      S_B1:    if (consume) state_d = S_B2;
      S_B2:    if (consume) state_d = S_B0;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_SEND_RST;
    endcase
    if (fail) state_d = (int'(retry_q) + 1 < MAX_RETRY) ? S_SEND_RST : S_ERR;
  end

  // Output logic
  always_comb begin
    rd_en_c   = 1'b0;
    err_c     = 1'b0;
    tx_req_d  = 1'b0;
    tx_data_d = tx_data_q;
    case (state_q)
      S_SEND_RST: begin tx_req_d = 1'b1; tx_data_d = 8'hFF; end
      S_SEND_EN:  begin tx_req_d = 1'b1; tx_data_d = 8'hF4; end
      S_WAIT_ACK1, S_WAIT_BAT, S_WAIT_ID, S_WAIT_ACK2,
      S_B0, S_B1, S_B2: rd_en_c = 1'b1;
      S_ERR:      err_c = 1'b1;
      default:    ;
    endcase
  end

  // Packet arithmetic: X follows dx, Y is inverted so mouse-up moves the cursor up.
  always_comb begin
    logic signed [POS_W+1:0] dx_s, dy_s, x_s, y_s;
    dx_s  = sext9(b0_q[4], dx_q);
    dy_s  = sext9(b0_q[5], rx_rd_data);
    x_s   = signed'({2'b00, x_q}) + dx_s;
    y_s   = signed'({2'b00, y_q}) - dy_s;
    x_new = b0_q[6] ? x_q : clamp_pos(x_s, XMAX_S);
    y_new = b0_q[7] ? y_q : clamp_pos(y_s, YMAX_S);
  end

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      retry_q     <= '0;
      b0_q        <= '0;
      dx_q        <= '0;
      tx_req_q    <= 1'b0;
      tx_data_q   <= '0;
      pkt_vld_q   <= 1'b0;
      init_done_q <= 1'b0;
      x_q         <= POS_W'(X_MAX / 2);
      y_q         <= POS_W'(Y_MAX / 2);
      btn_q       <= '0;
    end else begin
      tx_req_q    <= tx_req_d;
      tx_data_q   <= tx_data_d;
      init_done_q <= (state_d == S_B0) || (state_d == S_B1) || (state_d == S_B2);
      pkt_vld_q   <= (state_q == S_B2) && consume;
      if (fail) retry_q <= retry_q + 1'b1;
      if ((state_q == S_B0) && consume && rx_rd_data[3]) b0_q <= rx_rd_data;
      if ((state_q == S_B1) && consume) dx_q <= rx_rd_data;
      if ((state_q == S_B2) && consume) begin
        x_q   <= x_new;
        y_q   <= y_new;
        btn_q <= b0_q[2:0];
      end
    end
  end

  assign tx_req    = tx_req_q;
  assign tx_data   = tx_data_q;
  assign rx_rd_en  = rd_en_c;
  assign mouse_x   = x_q;
  assign mouse_y   = y_q;
  assign mouse_btn = btn_q;
  assign pkt_vld   = pkt_vld_q;
  assign init_done = init_done_q;
  assign init_err  = err_c;

endmodule

// File: tb/tb_ps2_mouse_ctrl.sv
// Directed bench for ps2_mouse_ctrl: init handshake, retries, timeout, packet decode, clamping, resync, reset.
module tb_ps2_mouse_ctrl;
  logic       clk_sys = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_req;
  logic [7:0] tx_data;
  logic       tx_done = 1'b0;
  logic       rx_rd_en;
  logic       rx_rd_vld = 1'b0;
  logic [7:0] rx_rd_data = 8'h00;
  logic [7:0] mouse_x, mouse_y;
  logic [2:0] mouse_btn;
  logic       pkt_vld, init_done, init_err;
  int chks = 0;
  int errs = 0;

  ps2_mouse_ctrl #(.X_MAX(159), .Y_MAX(119), .POS_W(8), .TIMEOUT_CYC(100), .MAX_RETRY(3)) dut (
    .clk_sys(clk_sys), .rst_n(rst_n), .tx_req(tx_req), .tx_data(tx_data), .tx_done(tx_done),
    .rx_rd_en(rx_rd_en), .rx_rd_vld(rx_rd_vld), .rx_rd_data(rx_rd_data),
    .mouse_x(mouse_x), .mouse_y(mouse_y), .mouse_btn(mouse_btn), .pkt_vld(pkt_vld),
    .init_done(init_done), .init_err(init_err));

  always #5 clk_sys = ~clk_sys;

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chks++;
    if (tx_req !== 1'b0 || tx_data !== 8'h00 || rx_rd_en !== 1'b0 || pkt_vld !== 1'b0 ||
        init_done !== 1'b0 || init_err !== 1'b0) begin
      errs++;
      $display("FAIL %s_ctrl got req=%b data=%h rd_en=%b pv=%b done=%b err=%b want all 0",
               tag, tx_req, tx_data, rx_rd_en, pkt_vld, init_done, init_err);
    end
    chks++;
    if (mouse_x !== 8'd79 || mouse_y !== 8'd59 || mouse_btn !== 3'b000) begin
      errs++;
      $display("FAIL %s_pos got (%0d,%0d) btn=%b want (79,59) btn=000", tag, mouse_x, mouse_y, mouse_btn);
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; rx_rd_vld = 1'b0; tx_done = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_tx(input logic [7:0] exp, input string tag);
    int n = 0;
    while (tx_req !== 1'b1 && n < 200) begin tick(); n++; end
    chks++;
    if (tx_req !== 1'b1 || tx_data !== exp) begin
      errs++;
      $display("FAIL %s got req=%b data=%h want req=1 data=%h", tag, tx_req, tx_data, exp);
    end
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chks++;
    if (tx_req !== 1'b0) begin
      errs++;
      $display("FAIL %s_pulse got req=%b want 0", tag, tx_req);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_rd_vld = 1'b1; rx_rd_data = b;
    while (rx_rd_en !== 1'b1 && n < 200) begin tick(); n++; end
    chks++;
    if (rx_rd_en !== 1'b1) begin
      errs++;
      $display("FAIL byte_accept %h got rd_en=%b want 1", b, rx_rd_en);
    end else tick();
    rx_rd_vld = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] p0, p1, p2, input int ex, ey, input logic [2:0] eb,
                          input string tag);
    send_byte(p0); send_byte(p1); send_byte(p2);
    chks++;
    if (pkt_vld !== 1'b1 || mouse_x !== 8'(ex) || mouse_y !== 8'(ey) || mouse_btn !== eb) begin
      errs++;
      $display("FAIL %s got pv=%b (%0d,%0d) btn=%b want pv=1 (%0d,%0d) btn=%b",
               tag, pkt_vld, mouse_x, mouse_y, mouse_btn, ex, ey, eb);
    end
    tick();
    chks++;
    if (pkt_vld !== 1'b0) begin
      errs++;
      $display("FAIL %s_pulse got pv=%b want 0", tag, pkt_vld);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
  endtask

  task automatic test_init();
    wait_tx(8'hFF, "init_tx_ff");
    send_byte(8'hFA); send_byte(8'hAA); send_byte(8'h00);
    wait_tx(8'hF4, "init_tx_f4");
    send_byte(8'hFA);
    chks++;
    if (init_done !== 1'b1 || init_err !== 1'b0 || mouse_x !== 8'd79 || mouse_y !== 8'd59) begin
      errs++;
      $display("FAIL init_done got done=%b err=%b (%0d,%0d) want done=1 err=0 (79,59)",
               init_done, init_err, mouse_x, mouse_y);
    end
  endtask

  task automatic test_packet();
    send_pkt(8'h09, 8'h05, 8'h03, 84, 56, 3'b001, "pkt_basic");
    send_pkt(8'h0E, 8'h00, 8'h00, 84, 56, 3'b110, "pkt_buttons");
  endtask

  task automatic test_clamp();
    send_pkt(8'h18, 8'h80, 8'h00, 0, 56, 3'b000, "clamp_x_low");
    send_pkt(8'h48, 8'h10, 8'h00, 0, 56, 3'b000, "x_overflow");
    send_pkt(8'h08, 8'h00, 8'h80, 0, 0, 3'b000, "clamp_y_low");
    send_pkt(8'h28, 8'h00, 8'h00, 0, 119, 3'b000, "clamp_y_high");
    send_pkt(8'h88, 8'h00, 8'h05, 0, 119, 3'b000, "y_overflow");
  endtask

  task automatic test_resync();
    send_byte(8'h05);
    send_pkt(8'h08, 8'h01, 8'h00, 1, 119, 3'b000, "resync");
  endtask

  task automatic test_reset_mid_packet();
    send_byte(8'h09); send_byte(8'h05);
    rst_n = 1'b0;
    tick();
    check_reset_outputs("reset_mid");
    rst_n = 1'b1;
  endtask

  task automatic test_bad_selftest();
    apply_reset();
    wait_tx(8'hFF, "bad_tx1");
    send_byte(8'hFA); send_byte(8'hFC);
    wait_tx(8'hFF, "bad_resend2");
    send_byte(8'hFA); send_byte(8'hFC);
    wait_tx(8'hFF, "bad_resend3");
    send_byte(8'hFA); send_byte(8'hFC);
    chks++;
    if (init_err !== 1'b1 || rx_rd_en !== 1'b0 || init_done !== 1'b0) begin
      errs++;
      $display("FAIL bad_err got err=%b rd_en=%b done=%b want err=1 rd_en=0 done=0",
               init_err, rx_rd_en, init_done);
    end
    begin
      int seen = 0;
      for (int i = 0; i < 50; i++) begin tick(); if (tx_req === 1'b1) seen++; end
      chks++;
      if (seen != 0 || init_err !== 1'b1) begin
        errs++;
        $display("FAIL bad_no_tx got %0d tx_req pulses err=%b want 0 pulses err=1", seen, init_err);
      end
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    apply_reset();
    wait_tx(8'hFF, "tmo_tx1");
    while (tx_req !== 1'b1 && n < 1000) begin tick(); n++; end
`ifdef PS2_TIMEOUT_EN
    chks++;
    if (tx_req !== 1'b1 || tx_data !== 8'hFF || n < 95 || n > 110) begin
      errs++;
      $display("FAIL tmo_resend got req=%b data=%h after %0d cycles want FF after ~101",
               tx_req, tx_data, n);
    end
`else
    chks++;
    if (tx_req !== 1'b0 || init_err !== 1'b0 || rx_rd_en !== 1'b1) begin
      errs++;
      $display("FAIL tmo_none got req=%b err=%b rd_en=%b after %0d cycles want req=0 err=0 rd_en=1",
               tx_req, init_err, rx_rd_en, n);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_init();
    test_packet();
    test_clamp();
    test_resync();
    test_reset_mid_packet();
    test_bad_selftest();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", chks, errs);
    $finish;
  end
endmodule
